// File: rtl/mem_arb_pkg.sv
// Shared encodings and default sizing for the memory arbiter.
package mem_arb_pkg;

    localparam int unsigned BLK_WORDS_DEF = 8;
    localparam int unsigned IDX_W         = $clog2(BLK_WORDS_DEF);

    typedef enum logic [1:0] {
        StIdle,
        StFill,
        StWrite,
        StDone
    } arb_state_e;

    typedef enum logic {
        OwnIc,
        OwnDc
    } owner_e;

endpackage

// File: rtl/fill_counter.sv
// Block word counter: synchronous clear, increment that stops at COUNT, terminal-count flag.
module fill_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned COUNT = BLK_WORDS_DEF,
    parameter int unsigned IDX_W = $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [IDX_W-1:0] idx,
    output logic             tc
);

    localparam int unsigned CW = IDX_W + 1;
    localparam logic [CW-1:0] COUNT_VAL = CW'(COUNT);
    localparam logic [CW-1:0] ONE       = CW'(1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (inc && !tc) begin
            cnt_q <= cnt_q + ONE;
        end
    end

    assign idx = cnt_q[IDX_W-1:0];
    assign tc  = (cnt_q == COUNT_VAL);

endmodule

// File: rtl/mem_arbiter.sv
// Shares main memory between I-cache block fills and D-cache fills/stores.
// Define ARB_RR_EN for round-robin tie-breaking; otherwise D-cache has fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BLK_WORDS = BLK_WORDS_DEF,
    parameter int unsigned MEM_LAT   = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ic_req,
    input  logic [ADDR_W-1:0]            ic_addr,
    output logic                         ic_done,
    input  logic                         dc_req,
    input  logic                         dc_wr,
    input  logic [ADDR_W-1:0]            dc_addr,
    input  logic [DATA_W-1:0]            dc_wdata,
    output logic                         dc_done,
    output logic                         mem_en,
    output logic                         mem_wr,
    output logic [ADDR_W-1:0]            mem_addr,
    output logic [DATA_W-1:0]            mem_wdata,
    input  logic [DATA_W-1:0]            mem_rdata,
    input  logic                         mem_valid,
    output logic [DATA_W-1:0]            fill_data,
    output logic [$clog2(BLK_WORDS)-1:0] fill_idx,
    output logic                         fill_we_ic,
    output logic                         fill_we_dc,
    output logic                         busy
);

    localparam int unsigned IW    = $clog2(BLK_WORDS);
    localparam int unsigned OFF_W = IW + 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(BLK_WORDS - 1);

    if ((BLK_WORDS & (BLK_WORDS - 1)) != 0 || BLK_WORDS < 2 || MEM_LAT == 0
            || ADDR_W <= OFF_W) begin : g_param_check
        $error("mem_arbiter: BLK_WORDS must be a power of 2 >= 2, MEM_LAT nonzero");
    end

    arb_state_e        state_q;
    owner_e            owner_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    logic [IW-1:0] issue_idx, recv_idx;
    logic          issue_tc, recv_tc;
    logic          in_fill, issue_inc, recv_inc;
    logic          pick_dc;

    assign in_fill   = (state_q == StFill);
    assign issue_inc = in_fill && !issue_tc;
    // Responses outside a fill, or beyond the last word, are dropped here.
    assign recv_inc  = in_fill && mem_valid && !recv_tc;

    fill_counter #(
        .COUNT (BLK_WORDS),
        .IDX_W (IW)
    ) u_issue_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!in_fill),
        .inc (issue_inc),
        .idx (issue_idx),
        .tc  (issue_tc)
    );

    fill_counter #(
        .COUNT (BLK_WORDS),
        .IDX_W (IW)
    ) u_recv_cnt (
        .clk (clk),
        .rst (rst),
        .clr (!in_fill),
        .inc (recv_inc),
        .idx (recv_idx),
        .tc  (recv_tc)
    );

`ifdef ARB_RR_EN
    owner_e last_q;

    // On a tie, grant the cache that was not served most recently.
    assign pick_dc = dc_req && (!ic_req || last_q == OwnIc);

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= OwnIc;
        end else if (state_q == StIdle && (ic_req || dc_req)) begin
            last_q <= pick_dc ? OwnDc : OwnIc;
        end
    end
`else
    assign pick_dc = dc_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= OwnIc;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (ic_req || dc_req) begin
                        owner_q <= pick_dc ? OwnDc : OwnIc;
                        addr_q  <= pick_dc ? dc_addr : ic_addr;
                        wdata_q <= dc_wdata;
                        state_q <= (pick_dc && dc_wr) ? StWrite : StFill;
                    end
                end
                StFill: begin
                    if (recv_inc && recv_idx == LAST_IDX) begin
                        state_q <= StDone;
                    end
                end
                StWrite: state_q <= StDone;
                StDone:  state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_wr    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (issue_inc) begin
            mem_en   = 1'b1;
            // Offset replaces the low address bits, so the block address never carries.
            mem_addr = {addr_q[ADDR_W-1:OFF_W], issue_idx, 1'b0};
        end else if (state_q == StWrite) begin
            mem_en    = 1'b1;
            mem_wr    = 1'b1;
            mem_addr  = addr_q;
            mem_wdata = wdata_q;
        end
    end

    assign fill_data  = recv_inc ? mem_rdata : '0;
    assign fill_idx   = recv_inc ? recv_idx : '0;
    assign fill_we_ic = recv_inc && (owner_q == OwnIc);
    assign fill_we_dc = recv_inc && (owner_q == OwnDc);

    assign ic_done = (state_q == StDone) && (owner_q == OwnIc);
    assign dc_done = (state_q == StDone) && (owner_q == OwnDc);
    assign busy    = (state_q != StIdle);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; the memory model returns (addr ^ 16'h5A5A) MEM_LAT cycles
// after each read issue.
module tb_mem_arbiter;

    localparam int unsigned ADDR_W    = 16;
    localparam int unsigned DATA_W    = 16;
    localparam int unsigned BLK_WORDS = 8;
    localparam int unsigned MEM_LAT   = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ic_req = 1'b0;
    logic [ADDR_W-1:0] ic_addr = '0;
    logic              ic_done;
    logic              dc_req = 1'b0;
    logic              dc_wr = 1'b0;
    logic [ADDR_W-1:0] dc_addr = '0;
    logic [DATA_W-1:0] dc_wdata = '0;
    logic              dc_done;
    logic              mem_en, mem_wr;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata, mem_rdata;
    logic              mem_valid;
    logic [DATA_W-1:0] fill_data;
    logic [2:0]        fill_idx;
    logic              fill_we_ic, fill_we_dc, busy;
    logic              inj_valid = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BLK_WORDS (BLK_WORDS),
        .MEM_LAT   (MEM_LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .ic_req     (ic_req),
        .ic_addr    (ic_addr),
        .ic_done    (ic_done),
        .dc_req     (dc_req),
        .dc_wr      (dc_wr),
        .dc_addr    (dc_addr),
        .dc_wdata   (dc_wdata),
        .dc_done    (dc_done),
        .mem_en     (mem_en),
        .mem_wr     (mem_wr),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_valid  (mem_valid),
        .fill_data  (fill_data),
        .fill_idx   (fill_idx),
        .fill_we_ic (fill_we_ic),
        .fill_we_dc (fill_we_dc),
        .busy       (busy)
    );

    // Memory model: fixed-latency read pipeline, not affected by arbiter reset.
    logic [MEM_LAT-1:0] pipe_v = '0;
    logic [ADDR_W-1:0]  pipe_a [MEM_LAT];

    always @(posedge clk) begin
        pipe_v    <= {pipe_v[MEM_LAT-2:0], mem_en & ~mem_wr};
        pipe_a[0] <= mem_addr;
        for (int i = 1; i < MEM_LAT; i++) pipe_a[i] <= pipe_a[i-1];
    end

    assign mem_valid = pipe_v[MEM_LAT-1] | inj_valid;
    assign mem_rdata = pipe_v[MEM_LAT-1] ? (pipe_a[MEM_LAT-1] ^ 16'h5A5A) : 16'h1111;

    // Event monitor, sampled on the falling edge.
    int cyc     = 0;
    int busy_n  = 0;
    int clash_n = 0;
    int rd_addr_q[$];
    int rd_cyc_q[$];
    int wr_addr_q[$];
    int wr_dat_q[$];
    int wr_cyc_q[$];
    int fill_idx_q[$];
    int fill_dat_q[$];
    int fill_own_q[$];
    int done_own_q[$];
    int done_cyc_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (busy) busy_n <= busy_n + 1;
        if (mem_en && !mem_wr) begin
            rd_addr_q.push_back(int'(mem_addr));
            rd_cyc_q.push_back(cyc);
        end
        if (mem_en && mem_wr) begin
            wr_addr_q.push_back(int'(mem_addr));
            wr_dat_q.push_back(int'(mem_wdata));
            wr_cyc_q.push_back(cyc);
        end
        if (fill_we_ic || fill_we_dc) begin
            fill_idx_q.push_back(int'(fill_idx));
            fill_dat_q.push_back(int'(fill_data));
            fill_own_q.push_back(fill_we_dc ? 1 : 0);
        end
        if (ic_done || dc_done) begin
            done_own_q.push_back(dc_done ? 1 : 0);
            done_cyc_q.push_back(cyc);
        end
        if ((fill_we_ic && fill_we_dc) || (ic_done && dc_done)) clash_n <= clash_n + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_dones(input int target, input string tag);
        int k = 0;
        while (done_own_q.size() < target && k < 100) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, 32'(done_own_q.size() >= target), 1);
    endtask

    task automatic check_fill(input string tag, input int rs, input int fs, input int base,
                              input int own);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_addr%0d", tag, i), rd_addr_q[rs+i], base + 2 * i);
            check($sformatf("%s_idx%0d", tag, i), fill_idx_q[fs+i], i);
            check($sformatf("%s_dat%0d", tag, i), fill_dat_q[fs+i], (base + 2 * i) ^ 'h5A5A);
            check($sformatf("%s_own%0d", tag, i), fill_own_q[fs+i], own);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rs, fs, ds, bs, ws, k, exp_own;

        // Reset state
        tick(3);
        check("rst_busy", busy, 0);
        check("rst_mem_en", mem_en, 0);
        check("rst_mem_wr", mem_wr, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_fill_we", {fill_we_ic, fill_we_dc}, 0);
        check("rst_done", {ic_done, dc_done}, 0);
        rst = 1'b0;

        // Idle with stray mem_valid
        fs = fill_idx_q.size(); ds = done_own_q.size(); bs = busy_n;
        for (int i = 0; i < 10; i++) begin
            inj_valid = i[0];
            tick();
        end
        inj_valid = 1'b0;
        tick();
        check("idle_busy_cycles", busy_n - bs, 0);
        check("idle_fill_we", fill_idx_q.size() - fs, 0);
        check("idle_done", done_own_q.size() - ds, 0);

        // I-cache fill, 0x1236 -> block 0x1230
        rs = rd_addr_q.size(); fs = fill_idx_q.size(); ds = done_own_q.size(); bs = busy_n;
        ic_addr = 16'h1236; ic_req = 1'b1;
        wait_dones(ds + 1, "ic");
        ic_req = 1'b0;
        check("ic_rd_n", rd_addr_q.size() - rs, 8);
        check("ic_fill_n", fill_idx_q.size() - fs, 8);
        check_fill("ic", rs, fs, 'h1230, 0);
        check("ic_rd_span", rd_cyc_q[rs+7] - rd_cyc_q[rs], 7);
        check("ic_done_own", done_own_q[ds], 0);
        check("ic_done_lat", done_cyc_q[ds] - rd_cyc_q[rs], 12);
        check("ic_busy_cycles", busy_n - bs, 13);

        // Simultaneous requests: D fill first, then the held I fill
        rs = rd_addr_q.size(); fs = fill_idx_q.size(); ds = done_own_q.size();
        ic_addr = 16'h0A10; dc_addr = 16'h2000; dc_wr = 1'b0;
        ic_req = 1'b1; dc_req = 1'b1;
        wait_dones(ds + 1, "both_d");
        dc_req = 1'b0;
        wait_dones(ds + 2, "both_i");
        ic_req = 1'b0;
        check("both_first_own", done_own_q[ds], 1);
        check("both_second_own", done_own_q[ds+1], 0);
        check("both_rd_n", rd_addr_q.size() - rs, 16);
        check_fill("both_d", rs, fs, 'h2000, 1);
        check_fill("both_i", rs + 8, fs + 8, 'h0A10, 0);
        check("both_i_start", rd_cyc_q[rs+8] - done_cyc_q[ds], 2);

        // D-cache write-through store
        rs = rd_addr_q.size(); ws = wr_addr_q.size(); ds = done_own_q.size();
        dc_wr = 1'b1; dc_addr = 16'h0040; dc_wdata = 16'hBEEF; dc_req = 1'b1;
        wait_dones(ds + 1, "wr");
        dc_req = 1'b0; dc_wr = 1'b0;
        check("wr_n", wr_addr_q.size() - ws, 1);
        check("wr_addr", wr_addr_q[ws], 'h0040);
        check("wr_data", wr_dat_q[ws], 'hBEEF);
        check("wr_no_reads", rd_addr_q.size() - rs, 0);
        check("wr_done_own", done_own_q[ds], 1);
        check("wr_done_lat", done_cyc_q[ds] - wr_cyc_q[ws], 1);

        // Top-of-memory block: no carry out of the block
        rs = rd_addr_q.size(); fs = fill_idx_q.size(); ds = done_own_q.size();
        ic_addr = 16'hFFF7; ic_req = 1'b1;
        wait_dones(ds + 1, "wrap");
        ic_req = 1'b0;
        check("wrap_rd_n", rd_addr_q.size() - rs, 8);
        check_fill("wrap", rs, fs, 'hFFF0, 0);

        // Reset during a fill, then a fresh fill
        fs = fill_idx_q.size();
        ic_addr = 16'h3000; ic_req = 1'b1;
        k = 0;
        while (fill_idx_q.size() - fs < 3 && k < 50) begin
            tick();
            k++;
        end
        check("mid_rst_reached", fill_idx_q.size() - fs, 3);
        rst = 1'b1; ic_req = 1'b0;
        tick();
        check("mid_rst_busy", busy, 0);
        rst = 1'b0;
        fs = fill_idx_q.size(); ds = done_own_q.size(); bs = busy_n;
        tick(8);
        check("mid_rst_late_we", fill_idx_q.size() - fs, 0);
        check("mid_rst_no_done", done_own_q.size() - ds, 0);
        check("mid_rst_idle", busy_n - bs, 0);
        rs = rd_addr_q.size(); fs = fill_idx_q.size(); ds = done_own_q.size();
        ic_addr = 16'h3456; ic_req = 1'b1;
        wait_dones(ds + 1, "post_rst");
        ic_req = 1'b0;
        check("post_rst_fill_n", fill_idx_q.size() - fs, 8);
        check_fill("post_rst", rs, fs, 'h3450, 0);

        // Repeated ties: round-robin alternates, fixed priority always picks D
        for (int r = 0; r < 4; r++) begin
            ds = done_own_q.size();
            ic_addr = 16'h5000 + 16'(r * 32);
            dc_addr = 16'h6000 + 16'(r * 32);
            dc_wr = 1'b0; ic_req = 1'b1; dc_req = 1'b1;
            wait_dones(ds + 1, $sformatf("tie%0d", r));
            ic_req = 1'b0; dc_req = 1'b0;
            tick(2);
`ifdef ARB_RR_EN
            exp_own = (r % 2 == 0) ? 1 : 0;
`else
            exp_own = 1;
`endif
            check($sformatf("tie%0d_grant", r), done_own_q[ds], exp_own);
            check($sformatf("tie%0d_single", r), done_own_q.size() - ds, 1);
        end

        check("no_clash", clash_n, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
